serial_mag_comparator: RTL and testbench



---
 rtl/serial_mag_comparator_pkg.sv | 35 +++
 rtl/serial_mag_comparator_if.sv | 26 ++
 rtl/bit_cmp_step.sv | 24 ++
 rtl/serial_mag_comparator.sv | 88 ++++++++
 tb/tb_serial_mag_comparator.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: verdict and FSM state
// encodings plus the verdict-to-flag decode used to drive gt/eq/lt.
package cmp_pkg;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Encoding 2'd3 is unused; it decodes to "no result" rather than a false verdict.
  function automatic cmp_flags_t decode_result(cmp_result_t r);
    cmp_flags_t f;
    f = '0;
    case (r)
      EQ:      f.eq = 1'b1;
      GT:      f.gt = 1'b1;
      LT:      f.lt = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Serial bit link and verdict bus between a bit source and the comparator.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             start;
  logic             bit_valid;
  logic             x_in;
  logic             y_in;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output start, bit_valid, x_in, y_in,
    input  busy, done, gt, eq, lt, bit_count
  );

  modport slave (
    input  start, bit_valid, x_in, y_in,
    output busy, done, gt, eq, lt, bit_count
  );
endinterface

// File: rtl/bit_cmp_step.sv
// One-bit compare step: folds a single (x,y) bit pair into the running verdict.
module bit_cmp_step
  import cmp_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  cmp_result_t verdict_i,
  input  logic        x_i,
  input  logic        y_i,
  output cmp_result_t verdict_o
);

  always_comb begin
    verdict_o = verdict_i;
    if (x_i != y_i) begin
      // MSB first: the earliest difference is the most significant, so freeze it.
      // LSB first: later differences are more significant, so they overwrite.
      if ((MSB_FIRST == 0) || (verdict_i == EQ)) begin
        verdict_o = x_i ? GT : LT;
      end
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: consumes WIDTH (x,y) bit pairs after a start
// and reports a registered one-hot gt/eq/lt verdict with a one-cycle done pulse.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_mag_comparator_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  cmp_result_t      verdict_q, verdict_d;
  cmp_flags_t       flags_q,   flags_d;
  logic             done_q,    done_d;
  cmp_result_t      step_verdict;

  bit_cmp_step #(
    .MSB_FIRST (MSB_FIRST)
  ) u_step (
    .verdict_i (verdict_q),
    .x_i       (bus.x_in),
    .y_i       (bus.y_in),
    .verdict_o (step_verdict)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    verdict_d = verdict_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          verdict_d = EQ;
          flags_d   = decode_result(EQ);
        end
      end
      SHIFT: begin
        // Stalls (bit_valid low) hold every register; start is ignored here.
        if (bus.bit_valid) begin
          verdict_d = step_verdict;
          flags_d   = decode_result(step_verdict);
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      verdict_q <= EQ;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      verdict_q <= verdict_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.gt        = flags_q.gt;
  assign bus.eq        = flags_q.eq;
  assign bus.lt        = flags_q.lt;
  assign bus.bit_count = cnt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Drives one bit stream into an MSB-first and an LSB-first comparator and
// checks both against integer comparisons of the words the stream encodes.
module tb_serial_mag_comparator;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic bv    = 1'b0;
  logic xi    = 1'b0;
  logic yi    = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_mag_comparator_if #(.WIDTH(W)) bm ();
  serial_mag_comparator_if #(.WIDTH(W)) bl ();

  assign bm.start = start;  assign bl.start = start;
  assign bm.bit_valid = bv; assign bl.bit_valid = bv;
  assign bm.x_in = xi;      assign bl.x_in = xi;
  assign bm.y_in = yi;      assign bl.y_in = yi;

  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(bm.slave));
  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(bl.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {gt,eq,lt} expected from comparing two unsigned integers.
  function automatic logic [2:0] ref_cmp(input int a, input int b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Stream bit i is s[7-i]. MSB-first reading of the first k+1 bits.
  function automatic int word_msb(input logic [7:0] s, input int k);
    return int'(s) >> (7 - k);
  endfunction

  // LSB-first reading: stream bit i has weight 2**i.
  function automatic int word_lsb(input logic [7:0] s, input int k);
    int r = 0;
    for (int i = 0; i <= k; i++) if (s[7-i]) r += (1 << i);
    return r;
  endfunction

  task automatic chk_verdict(input string tag, input logic [7:0] xs, input logic [7:0] ys, input int k);
    chk({tag, "_vm"}, 32'({bm.gt, bm.eq, bm.lt}), 32'(ref_cmp(word_msb(xs, k), word_msb(ys, k))));
    chk({tag, "_vl"}, 32'({bl.gt, bl.eq, bl.lt}), 32'(ref_cmp(word_lsb(xs, k), word_lsb(ys, k))));
  endtask

  task automatic chk_count(input string tag, input int c);
    chk({tag, "_cnt"}, 32'({bm.bit_count, bl.bit_count}), 32'({CW'(c), CW'(c)}));
  endtask

  task automatic chk_started(input string tag);
    chk({tag, "_busy"}, 32'({bm.busy, bl.busy}), 32'b11);
    chk({tag, "_done"}, 32'({bm.done, bl.done}), 32'b00);
    chk({tag, "_eqm"}, 32'({bm.gt, bm.eq, bm.lt}), 32'b010);
    chk({tag, "_eql"}, 32'({bl.gt, bl.eq, bl.lt}), 32'b010);
    chk_count(tag, 0);
  endtask

  // xs/ys are streamed bit 7 first. gap_at: stall gap_len cycles after that bit.
  // start_at: raise start alongside that bit (must be ignored). chain: start in the done cycle.
  task automatic run_cmp(input logic [7:0] xs, input logic [7:0] ys, input int gap_at,
                         input int gap_len, input int start_at, input bit chain, input bit no_start);
    if (!no_start) begin
      start = 1'b1; bv = 1'($urandom); xi = 1'($urandom); yi = 1'($urandom);
      cyc();
      start = 1'b0;
      chk_started("start");
    end
    for (int k = 0; k < W; k++) begin
      bv = 1'b1; xi = xs[7-k]; yi = ys[7-k];
      start = (k == start_at);
      cyc();
      start = 1'b0;
      if (k < W - 1) begin
        chk("run_done", 32'({bm.done, bl.done}), 32'b00);
        chk("run_busy", 32'({bm.busy, bl.busy}), 32'b11);
        chk_count("run", k + 1);
        chk_verdict("run", xs, ys, k);
        if (k == gap_at) begin
          for (int g = 0; g < gap_len; g++) begin
            bv = 1'b0; xi = 1'($urandom); yi = 1'($urandom);
            cyc();
            chk("gap_busy", 32'({bm.busy, bl.busy}), 32'b11);
            chk("gap_done", 32'({bm.done, bl.done}), 32'b00);
            chk_count("gap", k + 1);
            chk_verdict("gap", xs, ys, k);
          end
        end
      end
    end
    bv = 1'b0;
    chk("fin_done", 32'({bm.done, bl.done}), 32'b11);
    chk("fin_busy", 32'({bm.busy, bl.busy}), 32'b00);
    chk_count("fin", W - 1);
    chk_verdict("fin", xs, ys, W - 1);
    if (chain) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk_started("chain");
    end else begin
      cyc();
      chk("post_done", 32'({bm.done, bl.done}), 32'b00);
      chk("post_busy", 32'({bm.busy, bl.busy}), 32'b00);
      chk_count("post", W - 1);
      chk_verdict("post", xs, ys, W - 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m"}, 32'({bm.busy, bm.done, bm.gt, bm.eq, bm.lt, bm.bit_count}), 32'd0);
    chk({tag, "_l"}, 32'({bl.busy, bl.done, bl.gt, bl.eq, bl.lt, bl.bit_count}), 32'd0);
  endtask

  initial begin
    logic [7:0] rx, ry;
    #1 rst = 1'b1;
    #1 chk_reset_vals("reset");
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk_reset_vals("idle");

    // MSB-first GT with no gaps.
    run_cmp(8'hA5, 8'h5A, -1, 0, -1, 1'b0, 1'b0);
    // Equal words with a 3-cycle stall after bit 4.
    run_cmp(8'h3C, 8'h3C, 4, 3, -1, 1'b0, 1'b0);
    // LSB-first X=0x01, Y=0x80 sent as reversed streams; LSB unit must end in LT.
    run_cmp(8'h80, 8'h01, -1, 0, -1, 1'b0, 1'b0);
    // Start during bit 3 is ignored; start in the done cycle chains a new compare.
    run_cmp(8'h96, 8'h69, -1, 0, 3, 1'b1, 1'b0);
    run_cmp(8'h12, 8'h34, -1, 0, -1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of bit 5.
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bv = 1'b1; xi = 1'(k & 1); yi = 1'(~k & 1);
      cyc();
    end
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    cyc();
    rst = 1'b0; bv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk("after_rst", 32'({bm.done, bl.done, bm.busy, bl.busy}), 32'd0);
    end
    run_cmp(8'h00, 8'hFF, -1, 0, -1, 1'b0, 1'b0);

    // Back-to-back compares.
    run_cmp(8'hFF, 8'hFE, -1, 0, -1, 1'b1, 1'b0);
    run_cmp(8'h10, 8'h10, -1, 0, -1, 1'b0, 1'b1);

    // Randomized words and stalls.
    for (int t = 0; t < 30; t++) begin
      rx = 8'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : 8'($urandom);
      run_cmp(rx, ry, $urandom_range(0, 7), $urandom_range(0, 3), -1,
              1'($urandom_range(0, 1)), 1'b0);
      if (bm.busy) begin
        run_cmp(8'($urandom), 8'($urandom), -1, 0, -1, 1'b0, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
